lcd_status_reader: RTL and testbench
====================================

# lcd_status_reader

Read side of the character-LCD bus. The block performs HD44780-style status reads (RS=0, RW=1), returning the busy flag and 7-bit address counter, so the LCD writer path can wait on busy instead of worst-case delays. It sits beside the LCD writer at the top level. The top level muxes the RS/RW/E lines while `bus_active`=1 and tri-states `lcd_DB` whenever `lcd_rw`=1.

## Interface
Parameters:
- `T_AS`, default 3: RS/RW setup cycles before E rises (≥1)
- `T_EH`, default 13: E-high cycles (≥1); data sampled on the last one
- `T_EL`, default 13: E-low cycles after E falls (≥1)
- `TIMEOUT`, default 100000: poll-mode cycle limit, about 2 ms at 50 MHz (≥ T_AS+T_EH+T_EL)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-low
- `req`  in  1  start a transaction; accepted only when `ready`=1
- `wait_idle`  in  1  sampled with accepted `req`. 1 means repeat reads until busy=0 or timeout.
- `ready`  out  1  block is in IDLE
- `bus_active`  out  1  block owns RS/RW/E (every state except IDLE)
- `done`  out  1  one-cycle pulse at transaction end
- `busy_flag`  out  1  last sampled DB[7]
- `addr_out`  out  7  last sampled DB[6:0]
- `timeout`  out  1  last poll ended by timeout; held until next accepted `req`
- `lcd_rs`  out  1  always 0
- `lcd_rw`  out  1  1 from SETUP through ELOW
- `lcd_e`  out  1  enable strobe
- `lcd_db_in`  in  8  LCD data bus, read side

## Operation
- FSM states: IDLE, SETUP, EHIGH, ELOW, FINISH. A shared phase counter reloads on every state entry.
- IDLE:
  - `ready`=1, `lcd_rw`=0, `lcd_e`=0.
  - When `req`=1, latch `wait_idle`, clear the timeout counter and `timeout`, then go to SETUP.
- SETUP: `lcd_rw`=1, `lcd_e`=0, for T_AS cycles, then EHIGH.
- EHIGH:
  - `lcd_e`=1 for T_EH cycles.
  - On the last cycle, register `lcd_db_in[7]` into `busy_flag` and `lcd_db_in[6:0]` into `addr_out`. Outputs update on the following edge.
- ELOW: `lcd_e`=0, `lcd_rw`=1, for T_EL cycles. On the last cycle:
  - Poll mode with busy=1 and timeout counter < TIMEOUT: return to SETUP.
  - Poll mode with busy=1 and timeout counter ≥ TIMEOUT: set `timeout`=1, go to FINISH.
  - Otherwise: go to FINISH.
- FINISH:
  - `done`=1, `ready`=0, `lcd_rw`=0, `lcd_e`=0. Next state is IDLE.
  - `busy_flag`/`addr_out` are valid with `done` and hold until overwritten.
- Timeout counter:
  - Counts every cycle from acceptance in poll mode and saturates at TIMEOUT.
  - It is checked only at ELOW end, so a read in progress always completes its E cycle.
- `req` outside IDLE is ignored, including in FINISH; it is not queued.
- `wait_idle` changes after acceptance have no effect.
- `lcd_rs` is constant 0.

## Timing
- Reset (asynchronous, `rst`=0):
  - State goes to IDLE immediately; `lcd_e`=0 without waiting for a clock.
  - All outputs read 0, except `ready`=1.
  - An aborted read leaves no `done` pulse.
- Single read, `req` accepted at edge 0:
  - SETUP edges 1..T_AS, EHIGH next T_EH, ELOW next T_EL.
  - `done` high in cycle T_AS+T_EH+T_EL+1, which is 30 with defaults.
  - `ready` returns the cycle after `done`.
- Each poll iteration costs T_AS+T_EH+T_EL cycles (29 with defaults).
- E-high period with defaults is 260 ns at 50 MHz, meeting the LCD minimum of 230 ns. The sample point is ≥160 ns after E rises.
- A back-to-back `req` held high is accepted the cycle `ready` rises. The minimum transaction spacing is T_AS+T_EH+T_EL+2 cycles.

## Structure
- Shared package `lcd_pkg`:
  - FSM state enum
  - default timing constants T_AS/T_EH/T_EL/TIMEOUT
  - bit index `LCD_BF_BIT`=7
  - RS/RW encodings shared with the LCD writer
- One sub-module, `lcd_phase_timer`:
  - loadable down-counter
  - `load`, `value` inputs; `last` output
  - width set from the max of T_AS/T_EH/T_EL
- The FSM, sample registers and timeout counter live in `lcd_status_reader`.

## Test plan
- Single read with `lcd_db_in`=8'h45, `wait_idle`=0 → `done` at cycle 30; `busy_flag`=0, `addr_out`=7'h45; E high exactly 13 cycles; RS=0 throughout.
- Poll mode, DB=8'hC0 for the first 2 reads then 8'h40 → three E pulses 29 cycles apart; `done` at cycle 88; `busy_flag`=0, `addr_out`=7'h40, `timeout`=0.
- Poll mode, DB stuck at 8'h80, TIMEOUT=200 → `done` with `timeout`=1 and `busy_flag`=1 after the 7th iteration ends (cycle 204); `timeout` clears on the next accepted `req`.
- `req` pulsed during EHIGH and during FINISH → ignored; exactly one `done` pulse.
- `rst` low mid-EHIGH → `lcd_e`, `lcd_rw`, `bus_active` go 0 asynchronously; no `done`; after release `ready`=1 and a new read completes normally.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus (reader and writer paths).
// Holds the reader FSM states, default timing and bus encodings.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EHIGH,
        ST_ELOW,
        ST_FINISH
    } lcd_rd_state_e;

    localparam int unsigned LCD_T_AS    = 3;
    localparam int unsigned LCD_T_EH    = 13;
    localparam int unsigned LCD_T_EL    = 13;
    localparam int unsigned LCD_TIMEOUT = 100000;

    localparam int unsigned LCD_BF_BIT = 7;

    localparam logic LCD_RS_CMD   = 1'b0;
    localparam logic LCD_RS_DATA  = 1'b1;
    localparam logic LCD_RW_WRITE = 1'b0;
    localparam logic LCD_RW_READ  = 1'b1;

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold 0..maxval-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned maxval);
        return ($clog2(maxval) < 1) ? 1 : $clog2(maxval);
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times each bus phase.
// `last` is high while the count sits at zero.
module lcd_phase_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload on request, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780 status read: returns busy flag and address counter,
// optionally polling until the controller reports not-busy.
module lcd_status_reader
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS    = LCD_T_AS,
    parameter int unsigned T_EH    = LCD_T_EH,
    parameter int unsigned T_EL    = LCD_T_EL,
    parameter int unsigned TIMEOUT = LCD_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       wait_idle,
    output logic       ready,
    output logic       bus_active,
    output logic       done,
    output logic       busy_flag,
    output logic [6:0] addr_out,
    output logic       timeout,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    input  logic [7:0] lcd_db_in
);

    localparam int unsigned PW = cnt_width(max3(T_AS, T_EH, T_EL));
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

    localparam logic [PW-1:0] LD_AS = PW'(T_AS - 1);
    localparam logic [PW-1:0] LD_EH = PW'(T_EH - 1);
    localparam logic [PW-1:0] LD_EL = PW'(T_EL - 1);

    lcd_rd_state_e state_q, state_d;
    logic          poll_q, poll_d;
    logic          busy_q, busy_d;
    logic [6:0]    addr_q, addr_d;
    logic          to_q, to_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    logic          ph_load;
    logic [PW-1:0] ph_value;
    logic          ph_last;

    lcd_phase_timer #(
        .W(PW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (ph_load),
        .value(ph_value),
        .last (ph_last)
    );

    // Next state, phase reloads, data sampling and timeout tracking.
    always_comb begin
        state_d  = state_q;
        poll_d   = poll_q;
        busy_d   = busy_q;
        addr_d   = addr_q;
        to_d     = to_q;
        to_cnt_d = to_cnt_q;
        ph_load  = 1'b0;
        ph_value = '0;

        if (state_q != ST_IDLE && poll_q && to_cnt_q < TO_MAX) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d  = ST_SETUP;
                    ph_load  = 1'b1;
                    ph_value = LD_AS;
                    poll_d   = wait_idle;
                    to_cnt_d = '0;
                    to_d     = 1'b0;
                end
            end
            ST_SETUP: begin
                if (ph_last) begin
                    state_d  = ST_EHIGH;
                    ph_load  = 1'b1;
                    ph_value = LD_EH;
                end
            end
            ST_EHIGH: begin
                if (ph_last) begin
                    busy_d   = lcd_db_in[LCD_BF_BIT];
                    addr_d   = lcd_db_in[6:0];
                    state_d  = ST_ELOW;
                    ph_load  = 1'b1;
                    ph_value = LD_EL;
                end
            end
            ST_ELOW: begin
                if (ph_last) begin
                    if (poll_q && busy_q) begin
                        if (to_cnt_q >= TO_MAX) begin
                            to_d    = 1'b1;
                            state_d = ST_FINISH;
                        end else begin
                            state_d  = ST_SETUP;
                            ph_load  = 1'b1;
                            ph_value = LD_AS;
                        end
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset drops the bus at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            poll_q   <= 1'b0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            to_q     <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            poll_q   <= poll_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            to_q     <= to_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Bus and handshake outputs decoded straight from state.
    always_comb begin
        ready      = (state_q == ST_IDLE);
        bus_active = (state_q != ST_IDLE);
        done       = (state_q == ST_FINISH);
        lcd_e      = (state_q == ST_EHIGH);
        lcd_rw     = LCD_RW_WRITE;
        if (state_q == ST_SETUP || state_q == ST_EHIGH ||
            state_q == ST_ELOW) begin
            lcd_rw = LCD_RW_READ;
        end
    end

    assign lcd_rs    = LCD_RS_CMD;
    assign busy_flag = busy_q;
    assign addr_out  = addr_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_lcd_status_reader.sv
// Directed bench for lcd_status_reader.
// Cycle n = clock period following accept edge n-1.
module tb_lcd_status_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic       wait_idle = 1'b0;
    logic       ready, bus_active, done;
    logic       busy_flag, timeout;
    logic [6:0] addr_out;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db_in = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor results
    int   m_done_cyc, m_done_cnt, m_e_cnt, m_rs_bad;
    int   m_rise [0:15];
    int   m_nrise;
    logic m_busy, m_to, m_ready_after, m_rw_fin;
    logic [6:0] m_addr;
    int   db_mode = 0;

    always #5 clk = ~clk;

    // Small TIMEOUT so the timeout scenario stays short.
    lcd_status_reader #(
        .T_AS(3), .T_EH(13), .T_EL(13), .TIMEOUT(200)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wait_idle(wait_idle),
        .ready(ready), .bus_active(bus_active), .done(done),
        .busy_flag(busy_flag), .addr_out(addr_out),
        .timeout(timeout), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_db_in(lcd_db_in)
    );

    // Called at a sample point with ready=1; returns in cycle 1.
    task automatic start_txn(input logic wi);
        req = 1'b1;
        wait_idle = wi;
        @(posedge clk); #1;
        req = 1'b0;
        wait_idle = ~wi;
    endtask

    task automatic monitor(input int ncyc, input int r1, input int r2);
        logic e_prev;
        int reads;
        e_prev = 1'b0;
        reads = 0;
        m_done_cyc = 0; m_done_cnt = 0; m_e_cnt = 0; m_rs_bad = 0;
        m_nrise = 0; m_busy = 1'bx; m_addr = 7'bx; m_to = 1'bx;
        m_ready_after = 1'bx; m_rw_fin = 1'bx;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            if (lcd_rs !== 1'b0) m_rs_bad++;
            if (lcd_e === 1'b1) m_e_cnt++;
            if (lcd_e === 1'b1 && !e_prev && m_nrise < 16) begin
                m_rise[m_nrise] = cyc;
                m_nrise++;
            end
            if (lcd_e === 1'b0 && e_prev) reads++;
            if (db_mode == 1) lcd_db_in = (reads < 2) ? 8'hC0 : 8'h40;
            if (done === 1'b1) begin
                m_done_cnt++;
                if (m_done_cyc == 0) begin
                    m_done_cyc = cyc;
                    m_busy = busy_flag;
                    m_addr = addr_out;
                    m_to = timeout;
                    m_rw_fin = lcd_rw;
                end
            end
            if (m_done_cyc != 0 && cyc == m_done_cyc + 1)
                m_ready_after = ready;
            e_prev = (lcd_e === 1'b1);
            req = (cyc == r1 || cyc == r2);
            @(posedge clk); #1;
        end
        req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ready, bus_active, done, lcd_e, lcd_rw, lcd_rs} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 100000",
                     {ready, bus_active, done, lcd_e, lcd_rw, lcd_rs});
        end
        n_checks++;
        if ({busy_flag, addr_out, timeout} !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 000",
                     {busy_flag, addr_out, timeout});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_read;
        db_mode = 0;
        lcd_db_in = 8'h45;
        start_txn(1'b0);
        n_checks++;
        if (lcd_rw !== 1'b1 || bus_active !== 1'b1 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_setup rw=%b act=%b rdy=%b want 1 1 0",
                     lcd_rw, bus_active, ready);
        end
        monitor(35, 0, 0);
        n_checks++;
        if (m_done_cyc !== 30) begin
            n_fail++;
            $display("FAIL single_done_cyc got %0d want 30", m_done_cyc);
        end
        n_checks++;
        if (m_busy !== 1'b0 || m_addr !== 7'h45) begin
            n_fail++;
            $display("FAIL single_data got bf=%b addr=%h want 0 45",
                     m_busy, m_addr);
        end
        n_checks++;
        if (m_e_cnt !== 13 || m_nrise !== 1 || m_rise[0] !== 4) begin
            n_fail++;
            $display("FAIL single_e got high=%0d pulses=%0d rise=%0d want 13 1 4",
                     m_e_cnt, m_nrise, m_rise[0]);
        end
        n_checks++;
        if (m_rs_bad !== 0) begin
            n_fail++;
            $display("FAIL single_rs got %0d bad cycles want 0", m_rs_bad);
        end
        n_checks++;
        if (m_ready_after !== 1'b1 || m_rw_fin !== 1'b0 || m_done_cnt !== 1) begin
            n_fail++;
            $display("FAIL single_end got rdy=%b rw=%b dones=%0d want 1 0 1",
                     m_ready_after, m_rw_fin, m_done_cnt);
        end
    endtask

    task automatic test_poll;
        db_mode = 1;
        lcd_db_in = 8'hC0;
        start_txn(1'b1);
        monitor(95, 0, 0);
        db_mode = 0;
        n_checks++;
        if (m_done_cyc !== 88) begin
            n_fail++;
            $display("FAIL poll_done_cyc got %0d want 88", m_done_cyc);
        end
        n_checks++;
        if (m_nrise !== 3 || m_rise[0] !== 4 || m_rise[1] !== 33 ||
            m_rise[2] !== 62) begin
            n_fail++;
            $display("FAIL poll_rises got n=%0d %0d %0d %0d want 3 4 33 62",
                     m_nrise, m_rise[0], m_rise[1], m_rise[2]);
        end
        n_checks++;
        if (m_busy !== 1'b0 || m_addr !== 7'h40 || m_to !== 1'b0) begin
            n_fail++;
            $display("FAIL poll_data got bf=%b addr=%h to=%b want 0 40 0",
                     m_busy, m_addr, m_to);
        end
    endtask

    task automatic test_timeout;
        db_mode = 0;
        lcd_db_in = 8'h80;
        start_txn(1'b1);
        monitor(210, 0, 0);
        n_checks++;
        if (m_done_cyc !== 204 || m_nrise !== 7) begin
            n_fail++;
            $display("FAIL to_done got cyc=%0d pulses=%0d want 204 7",
                     m_done_cyc, m_nrise);
        end
        n_checks++;
        if (m_to !== 1'b1 || m_busy !== 1'b1 || m_addr !== 7'h00) begin
            n_fail++;
            $display("FAIL to_flags got to=%b bf=%b addr=%h want 1 1 00",
                     m_to, m_busy, m_addr);
        end
        n_checks++;
        if (timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_hold got %b want 1", timeout);
        end
        lcd_db_in = 8'h12;
        start_txn(1'b0);
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_clear got %b want 0", timeout);
        end
        monitor(35, 0, 0);
        n_checks++;
        if (m_done_cyc !== 30 || m_addr !== 7'h12 || m_to !== 1'b0) begin
            n_fail++;
            $display("FAIL to_next got cyc=%0d addr=%h to=%b want 30 12 0",
                     m_done_cyc, m_addr, m_to);
        end
    endtask

    task automatic test_req_ignored;
        lcd_db_in = 8'h2A;
        start_txn(1'b0);
        monitor(70, 10, 30);
        n_checks++;
        if (m_done_cnt !== 1 || m_done_cyc !== 30 || m_nrise !== 1) begin
            n_fail++;
            $display("FAIL req_ignore got dones=%0d cyc=%0d pulses=%0d want 1 30 1",
                     m_done_cnt, m_done_cyc, m_nrise);
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ignore_idle got rdy=%b want 1", ready);
        end
    endtask

    task automatic test_async_reset;
        int dones;
        dones = 0;
        lcd_db_in = 8'h45;
        start_txn(1'b0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (lcd_e !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre got e=%b want 1", lcd_e);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({lcd_e, lcd_rw, bus_active, done, ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL arst_async got %b want 00001",
                     {lcd_e, lcd_rw, bus_active, done, ready});
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_after got dones=%0d rdy=%b want 0 1", dones, ready);
        end
        lcd_db_in = 8'h07;
        start_txn(1'b0);
        monitor(35, 0, 0);
        n_checks++;
        if (m_done_cyc !== 30 || m_addr !== 7'h07 || m_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_read got cyc=%0d addr=%h bf=%b want 30 07 0",
                     m_done_cyc, m_addr, m_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_poll();
        test_timeout();
        test_req_ignored();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
